exec_cycle_ctrl: RTL and testbench
==================================

Name: exec_cycle_ctrl

Overview:
- Multi-cycle fetch/decode/execute/memory/writeback sequencer driving the program counter block.
- Issues its write_en/load/new_pc controls.
- Handshakes instruction and data memory requests.
- Holds the instruction register and reports retire count, halt state and memory-timeout error.

Parameters:
- OP_BRANCH, 6'h04, opcode (ir[31:26]) of conditional branch
- OP_LOAD, 6'h23, opcode of load
- OP_STORE, 6'h2B, opcode of store
- OP_HALT, 6'h3F, opcode of halt
- MEM_TIMEOUT, 16, max wait cycles for any memory ready (>=2)

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- start  in  1  leave IDLE/HALTED and begin fetching
- halt_req  in  1  stop after current instruction retires
- pc_in  in  32  current PC from pc block
- pc_write_en  out  1  pc block write enable
- pc_load  out  1  pc block load select (1 = take pc_new, 0 = +4)
- pc_new  out  32  branch target to pc block
- branch_taken  in  1  branch condition from ALU, valid in EXECUTE
- branch_target  in  32  branch address, valid in EXECUTE
- imem_req  out  1  instruction read request
- imem_addr  out  32  equals pc_in
- imem_ready  in  1  instruction data valid
- imem_rdata  in  32  instruction word
- dmem_req  out  1  data access request
- dmem_we  out  1  1 = store, 0 = load; valid while dmem_req
- dmem_ready  in  1  data access complete
- rf_write_en  out  1  register-file write strobe
- ir  out  32  instruction register
- state  out  3  current state encoding
- instr_count  out  32  retired instructions, wraps 0xFFFFFFFF -> 0
- err  out  1  sticky memory-timeout flag

Behaviour:
- States: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, HALTED=6.
- Reset (reset=0, any time, including mid-request): state=IDLE, ir=0, instr_count=0, err=0, wait counter=0. All outputs are combinational and derive to 0 from IDLE.
- IDLE: start=1 -> FETCH next cycle; otherwise stay.
- FETCH:
  - imem_req=1 and imem_addr=pc_in, held until imem_ready.
  - Cycle with imem_ready=1: ir<=imem_rdata, -> DECODE. A fetch therefore costs 1 cycle minimum.
- DECODE (1 cycle):
  - opcode==OP_HALT -> HALTED. No PC write, not counted as retired.
  - Otherwise -> EXECUTE.
- EXECUTE (1 cycle):
  - Branch: pc_write_en=1, pc_load=branch_taken, pc_new=branch_target; the instruction retires.
  - Load/store -> MEMORY.
  - Any other opcode -> WRITEBACK.
- MEMORY:
  - dmem_req=1; dmem_we=1 for store, 0 for load; held until dmem_ready.
  - Store, on the ready cycle: pc_write_en=1, pc_load=0; retires.
  - Load, on the ready cycle: -> WRITEBACK.
- WRITEBACK (1 cycle): rf_write_en=1, pc_write_en=1, pc_load=0; retires.
- Retire cycle (any cycle with pc_write_en=1):
  - instr_count+1.
  - Next state = HALTED if halt_req=1 that cycle, else FETCH.
  - halt_req in any other cycle is ignored; an instruction is never abandoned.
- pc_load and pc_new are 0 whenever pc_write_en=0.
- Timeout:
  - Wait counter clears on every state entry and increments each FETCH/MEMORY cycle without ready.
  - If the counter reaches MEM_TIMEOUT-1 while ready is still 0: err<=1, -> HALTED, request drops next cycle, no retire.
  - Ready on that same cycle wins: no error.
- HALTED:
  - All strobes 0.
  - start=1 -> FETCH; err is not cleared (only reset clears err).
  - start and halt_req together on a retire cycle: halt wins.
- Latencies with zero-wait memory:
  - ALU op 4 cycles.
  - Branch 3 cycles.
  - Load 5 cycles.
  - Store 4 cycles.

Test Plan:
- Reset, start=1, pc_in=0, imem_ready=1, imem_rdata=ALU opcode 0x00 -> states 1,2,3,5; rf_write_en and pc_write_en high in cycle 4 with pc_load=0; instr_count=1; back to FETCH.
- Branch 0x10000000 with branch_taken=1, branch_target=0x40 -> pc_write_en=1, pc_load=1, pc_new=0x40 in EXECUTE; repeat with branch_taken=0 -> pc_load=0, pc_new=0.
- Load with dmem_ready delayed 3 cycles -> dmem_req high exactly 4 cycles with dmem_we=0, then WRITEBACK, instr_count+1. Store -> dmem_we=1, PC write on the ready cycle, no rf_write_en.
- imem_ready held 0 -> err=1 and state=6 after 16 FETCH cycles, imem_req low afterwards; start -> FETCH with err still 1.
- halt_req pulsed during WRITEBACK -> HALTED after retire, instr_count incremented. Fetch of an OP_HALT word -> HALTED with no PC write.
- reset asserted mid-MEMORY -> immediately state=0, dmem_req=0, ir=0, instr_count=0.

Source files
------------

// File: rtl/exec_cycle_ctrl.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer. It drives the PC block,
// handshakes the instruction and data memories, and tracks retirements and timeouts.
module exec_cycle_ctrl #(
    parameter logic [5:0] OP_BRANCH   = 6'h04,
    parameter logic [5:0] OP_LOAD     = 6'h23,
    parameter logic [5:0] OP_STORE    = 6'h2B,
    parameter logic [5:0] OP_HALT     = 6'h3F,
    parameter int         MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        halt_req,
    input  logic [31:0] pc_in,
    output logic        pc_write_en,
    output logic        pc_load,
    output logic [31:0] pc_new,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ready,
    output logic        rf_write_en,
    output logic [31:0] ir,
    output logic [2:0]  state,
    output logic [31:0] instr_count,
    output logic        err
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT) + 1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        DECODE    = 3'd2,
        EXECUTE   = 3'd3,
        MEMORY    = 3'd4,
        WRITEBACK = 3'd5,
        HALTED    = 3'd6
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] wait_cnt;
    logic [31:0]      ir_q;
    logic [31:0]      count_q;
    logic             err_q;
    logic [5:0]       opcode;
    logic             is_branch;
    logic             is_load;
    logic             is_store;
    logic             at_limit;
    logic             timeout;

    assign opcode    = ir_q[31:26];
    assign is_branch = (opcode == OP_BRANCH);
    assign is_load   = (opcode == OP_LOAD);
    assign is_store  = (opcode == OP_STORE);
    assign at_limit  = (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));

    // Any cycle that writes the PC is a retire; halt_req is only honoured there.
    always_comb begin
        state_d     = state_q;
        pc_write_en = 1'b0;
        pc_load     = 1'b0;
        pc_new      = '0;
        imem_req    = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        rf_write_en = 1'b0;
        timeout     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    state_d = DECODE;
                end else if (at_limit) begin
                    timeout = 1'b1;
                    state_d = HALTED;
                end
            end
            DECODE: begin
                state_d = (opcode == OP_HALT) ? HALTED : EXECUTE;
            end
            EXECUTE: begin
                if (is_branch) begin
                    pc_write_en = 1'b1;
                    pc_load     = branch_taken;
                    pc_new      = branch_taken ? branch_target : '0;
                end else if (is_load || is_store) begin
                    state_d = MEMORY;
                end else begin
                    state_d = WRITEBACK;
                end
            end
            MEMORY: begin
                dmem_req = 1'b1;
                dmem_we  = is_store;
                if (dmem_ready) begin
                    if (is_store) pc_write_en = 1'b1;
                    else          state_d     = WRITEBACK;
                end else if (at_limit) begin
                    timeout = 1'b1;
                    state_d = HALTED;
                end
            end
            WRITEBACK: begin
                rf_write_en = 1'b1;
                pc_write_en = 1'b1;
            end
            HALTED: begin
                if (start) state_d = FETCH;
            end
            default: state_d = IDLE;
        endcase
        if (pc_write_en) state_d = halt_req ? HALTED : FETCH;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            ir_q     <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
            wait_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == FETCH && imem_ready) ir_q <= imem_rdata;
            if (pc_write_en) count_q <= count_q + 32'd1;
            if (timeout) err_q <= 1'b1;
            if (state_d != state_q) begin
                wait_cnt <= '0;
            end else if ((imem_req && !imem_ready) || (dmem_req && !dmem_ready)) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
        end
    end

    assign imem_addr   = imem_req ? pc_in : '0;
    assign ir          = ir_q;
    assign state       = state_q;
    assign instr_count = count_q;
    assign err         = err_q;

endmodule

// File: tb/tb_exec_cycle_ctrl.sv
// Randomised bench for exec_cycle_ctrl: a driver issues instructions and queues the
// expected retire events, and a negedge monitor pops and compares them.
module tb_exec_cycle_ctrl;

    localparam logic [5:0] OP_BRANCH = 6'h04;
    localparam logic [5:0] OP_LOAD   = 6'h23;
    localparam logic [5:0] OP_STORE  = 6'h2B;
    localparam logic [5:0] OP_HALT   = 6'h3F;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        halt_req;
    logic [31:0] pc_in;
    logic        pc_write_en;
    logic        pc_load;
    logic [31:0] pc_new;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ready;
    logic        rf_write_en;
    logic [31:0] ir;
    logic [2:0]  state;
    logic [31:0] instr_count;
    logic        err;

    always #5 clk = ~clk;

    exec_cycle_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .halt_req(halt_req), .pc_in(pc_in),
        .pc_write_en(pc_write_en), .pc_load(pc_load), .pc_new(pc_new),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rdata(imem_rdata), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_ready(dmem_ready), .rf_write_en(rf_write_en), .ir(ir), .state(state),
        .instr_count(instr_count), .err(err)
    );

    typedef struct {
        logic        pc_load;
        logic [31:0] pc_new;
        logic        rf_we;
        logic [31:0] count;
        int          latency;
        int          start_cyc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    bit   mon_en = 0;
    bit   rand_halt = 0;
    int   model_count = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        halt_req = rand_halt && ($urandom_range(0, 5) == 0);
    endtask

    function automatic int pick_delay();
        if ($urandom_range(0, 9) == 0) return 15;
        return int'($urandom_range(0, 3));
    endfunction

    // Keeps start high while idle or halted so the sequencer always comes back to FETCH.
    task automatic wait_fetch(output bit ok);
        int n = 0;
        while (!imem_req && n < 64) begin
            start = (state == 3'd6 || state == 3'd0);
            step();
            n++;
        end
        start = 1'b0;
        ok = imem_req;
    endtask

    // kind: 0 ALU, 1 branch, 2 load, 3 store, 4 halt opcode
    task automatic apply_stimulus(input int kind, output bit ok);
        exp_t        e;
        logic [5:0]  op;
        logic [31:0] word;
        int          fd;
        int          md;
        wait_fetch(ok);
        if (!ok) begin
            total++;
            bad++;
            $display("[TB] FAIL fetch_wait: imem_req=%0b state=%0d required imem_req=1", imem_req, state);
            return;
        end
        case (kind)
            0: begin
                do op = 6'($urandom);
                while (op == OP_BRANCH || op == OP_LOAD || op == OP_STORE || op == OP_HALT);
            end
            1:       op = OP_BRANCH;
            2:       op = OP_LOAD;
            3:       op = OP_STORE;
            default: op = OP_HALT;
        endcase
        word          = {op, 26'($urandom)};
        fd            = pick_delay();
        md            = pick_delay();
        pc_in         = $urandom;
        branch_taken  = 1'($urandom_range(0, 1));
        branch_target = $urandom;
        #1;
        check_output("imem_addr", imem_addr, pc_in);
        if (kind != 4) begin
            e.pc_load   = (kind == 1) && branch_taken;
            e.pc_new    = e.pc_load ? branch_target : 32'd0;
            e.rf_we     = (kind == 0 || kind == 2);
            e.count     = 32'(model_count);
            e.latency   = fd + 1 + ((kind == 1) ? 2 : (kind == 0) ? 3 : (kind == 3) ? 3 + md : 4 + md);
            e.start_cyc = cyc;
            model_count++;
            sb.push_back(e);
        end
        imem_ready = 1'b0;
        for (int i = 0; i < fd; i++) step();
        imem_ready = 1'b1;
        imem_rdata = word;
        step();
        imem_ready = 1'b0;
        imem_rdata = $urandom;
        check_output("ir", ir, word);
        if (kind == 4) begin
            step();
            check_output("halt_opcode_state", 32'(state), 32'd6);
            return;
        end
        if (kind == 2 || kind == 3) begin
            step();
            step();
            check_output("dmem_req", 32'(dmem_req), 32'd1);
            check_output("dmem_we", 32'(dmem_we), 32'(kind == 3));
            for (int i = 0; i < md; i++) begin
                dmem_ready = 1'b0;
                step();
            end
            dmem_ready = 1'b1;
            step();
            dmem_ready = 1'b0;
        end
    endtask

    // Monitor: every PC write is a retire and must match the head of the scoreboard.
    initial begin
        exp_t e;
        bit   chk_next = 0;
        logic halt_seen = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (chk_next) begin
                    chk_next = 0;
                    check_output("post_retire_state", 32'(state), halt_seen ? 32'd6 : 32'd1);
                end
                if (pc_write_en) begin
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("[TB] FAIL unexpected_retire: pc_write_en=1 with nothing outstanding (cycle %0d)", cyc);
                    end else begin
                        e = sb.pop_front();
                        check_output("pc_load", 32'(pc_load), 32'(e.pc_load));
                        check_output("pc_new", pc_new, e.pc_new);
                        check_output("rf_write_en", 32'(rf_write_en), 32'(e.rf_we));
                        check_output("instr_count", instr_count, e.count);
                        check_output("latency", 32'(cyc - e.start_cyc + 1), 32'(e.latency));
                    end
                    chk_next  = 1;
                    halt_seen = halt_req;
                end else begin
                    check_output("pc_gate", pc_new | {31'd0, pc_load} | {31'd0, rf_write_en}, 32'd0);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit ok;
        int n;
        int kind;
        int r;
        reset = 1'b0;
        start = 1'b0;
        halt_req = 1'b0;
        pc_in = '0;
        branch_taken = 1'b0;
        branch_target = '0;
        imem_ready = 1'b0;
        imem_rdata = '0;
        dmem_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_output("rst_state", 32'(state), 32'd0);
        check_output("rst_ir", ir, 32'd0);
        check_output("rst_count", instr_count, 32'd0);
        check_output("rst_err", 32'(err), 32'd0);
        check_output("rst_strobes", {28'd0, pc_write_en, imem_req, dmem_req, rf_write_en}, 32'd0);
        reset = 1'b1;
        step();
        check_output("idle_hold", 32'(state), 32'd0);

        mon_en = 1;
        rand_halt = 1;
        ok = 1;
        for (int i = 0; i < 80 && ok; i++) begin
            r = int'($urandom_range(0, 9));
            kind = (r < 3) ? 0 : (r < 5) ? 1 : (r < 7) ? 2 : (r < 9) ? 3 : 4;
            apply_stimulus(kind, ok);
        end
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            step();
            n++;
        end
        check_output("scoreboard_drained", 32'(sb.size()), 32'd0);
        check_output("final_count", instr_count, 32'(model_count));
        check_output("no_err", 32'(err), 32'd0);

        rand_halt = 0;
        halt_req = 1'b0;
        wait_fetch(ok);
        imem_ready = 1'b0;
        n = 1;
        step();
        while (state == 3'd1 && n < 40) begin
            n++;
            step();
        end
        check_output("timeout_cycles", 32'(n), 32'd16);
        check_output("timeout_state", 32'(state), 32'd6);
        check_output("timeout_err", 32'(err), 32'd1);
        check_output("timeout_req_drop", 32'(imem_req), 32'd0);
        wait_fetch(ok);
        check_output("restart_state", 32'(state), 32'd1);
        check_output("err_sticky", 32'(err), 32'd1);

        imem_ready = 1'b1;
        imem_rdata = {OP_LOAD, 26'h5};
        step();
        imem_ready = 1'b0;
        step();
        step();
        check_output("mem_req_before_reset", 32'(dmem_req), 32'd1);
        step();
        mon_en = 0;
        reset = 1'b0;
        #1;
        check_output("midmem_rst_state", 32'(state), 32'd0);
        check_output("midmem_rst_dmem_req", 32'(dmem_req), 32'd0);
        check_output("midmem_rst_ir", ir, 32'd0);
        check_output("midmem_rst_count", instr_count, 32'd0);
        check_output("midmem_rst_err", 32'(err), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
